// File: rtl/sipo_deser_pkg.sv
// sipo_deser_pkg: shared types and sizing helpers for the sipo_deser slice.
//   state_t       : deserializer FSM states (PAR only reachable when the
//                   SIPO_DESER_PARITY_EN macro is defined)
//   cnt_width()   : bit counter width for a given word width, $clog2(WIDTH+1)
package sipo_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT + 1);

  // Counter must be able to hold the value WIDTH itself (PAR waits at WIDTH).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_deser_out_reg.sv
// sipo_deser_out_reg: single-entry holding register with valid/ready output.
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : a completed word is offered this cycle
//   i_word       : the completed word
//   i_ready      : downstream accepts o_data when o_valid=1
//   o_data       : held word, stable while o_valid=1 and i_ready=0
//   o_valid      : o_data holds an undelivered word
//   o_overrun    : sticky, a completed word was dropped (cleared by rst only)
module sipo_deser_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_accept;

  // Register is free if empty or being drained in this same cycle.
  assign w_accept = ~r_valid | i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_load && w_accept) begin
        r_data  <= i_word;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_load && !w_accept) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel deserializer with start-of-frame alignment.
// Optional even-parity bit after each word: define SIPO_DESER_PARITY_EN.
//   clk, rst    : clock, synchronous active-high reset
//   s_bit       : serial data bit, sampled when s_valid=1
//   s_valid     : s_bit valid this cycle (no input backpressure)
//   s_sof       : s_bit is bit 0 of a new frame (qualified by s_valid)
//   m_data      : assembled word
//   m_valid     : m_data holds an undelivered word
//   m_ready     : downstream accepts m_data
//   overrun     : sticky, a completed word was dropped
//   frame_err   : one-cycle pulse, s_sof arrived mid-word
//   parity_err  : one-cycle pulse, parity mismatch (tied 0 without parity)
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_bit,
  input  logic             s_valid,
  input  logic             s_sof,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_frame_err;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shift_d;
  logic [WIDTH-1:0] w_word;
  logic             w_load;
  logic             w_ferr_nxt;
`ifdef SIPO_DESER_PARITY_EN
  logic             r_parity_err;
  logic             w_perr_nxt;
`endif

  assign w_cnt_inc = r_cnt + 1'b1;

  // A new word (counter 0) or a fresh frame starts from an empty register,
  // so stale bits never leak into the next word.
  always_comb begin
    w_base = (r_cnt == '0 || s_sof) ? '0 : r_shift;
    if (MSB_FIRST) begin
      w_shift_nxt = {w_base[WIDTH-2:0], s_bit};
    end else begin
      w_shift_nxt = {s_bit, w_base[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_d   = r_shift;
    w_word      = w_shift_nxt;
    w_load      = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
    w_perr_nxt  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (s_valid && s_sof) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = CNT_W'(1);
          w_shift_d   = w_shift_nxt;
        end
      end
      SHIFT: begin
        if (s_valid) begin
          w_shift_d = w_shift_nxt;
          if (s_sof && r_cnt != '0) begin
            w_ferr_nxt = 1'b1;
            w_cnt_nxt  = CNT_W'(1);
          end else if (w_cnt_inc == CNT_W'(WIDTH)) begin
`ifdef SIPO_DESER_PARITY_EN
            // Counter parks at WIDTH while the parity bit is awaited.
            w_state_nxt = PAR;
            w_cnt_nxt   = w_cnt_inc;
`else
            w_load    = 1'b1;
            w_cnt_nxt = '0;
`endif
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
`ifdef SIPO_DESER_PARITY_EN
      PAR: begin
        w_word = r_shift;
        if (s_valid) begin
          w_state_nxt = SHIFT;
          if (s_sof) begin
            w_ferr_nxt = 1'b1;
            w_cnt_nxt  = CNT_W'(1);
            w_shift_d  = w_shift_nxt;
          end else begin
            w_cnt_nxt = '0;
            if (s_bit == ^r_shift) begin
              w_load = 1'b1;
            end else begin
              w_perr_nxt = 1'b1;
            end
          end
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_d;
      r_frame_err <= w_ferr_nxt;
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_perr_nxt;
    end
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign frame_err = r_frame_err;

  sipo_deser_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_word    (w_word),
    .i_ready   (m_ready),
    .o_data    (m_data),
    .o_valid   (m_valid),
    .o_overrun (overrun)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: bench for sipo_deser. Two instances (MSB-first and
// LSB-first) share one input stream; a bit-list model predicts all outputs.
// Honours SIPO_DESER_PARITY_EN when defined for the build.
module tb_sipo_deser;

  localparam int W = 8;
`ifdef SIPO_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_bit = 1'b0, s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b0;
  logic [W-1:0] d_msb, d_lsb;
  logic         v_msb, v_lsb, ov_msb, ov_lsb, fe_msb, fe_lsb, pe_msb, pe_lsb;

  int n_chk = 0;
  int n_fail = 0;
  int fe_seen = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .s_bit(s_bit), .s_valid(s_valid), .s_sof(s_sof),
    .m_data(d_msb), .m_valid(v_msb), .m_ready(m_ready),
    .overrun(ov_msb), .frame_err(fe_msb), .parity_err(pe_msb));

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .s_bit(s_bit), .s_valid(s_valid), .s_sof(s_sof),
    .m_data(d_lsb), .m_valid(v_lsb), .m_ready(m_ready),
    .overrun(ov_lsb), .frame_err(fe_lsb), .parity_err(pe_lsb));

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit           e_in_frame;
  bit           e_bits[$];
  bit           e_valid, e_ov, e_fe, e_pe;
  logic [W-1:0] e_dm, e_dl;

  // Place received bits by arrival order: position i is bit i of the frame.
  function automatic logic [W-1:0] pack(input bit msb_first);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb_first) w[W-1-i] = e_bits[i];
      else           w[i]     = e_bits[i];
    end
    return w;
  endfunction

  function automatic bit ones_parity();
    bit p = 1'b0;
    foreach (e_bits[i]) p ^= e_bits[i];
    return p;
  endfunction

  task automatic model_step();
    bit           complete = 1'b0;
    bit           xfer;
    logic [W-1:0] wm = '0, wl = '0;
    if (rst) begin
      e_in_frame = 1'b0; e_bits.delete();
      e_valid = 1'b0; e_ov = 1'b0; e_fe = 1'b0; e_pe = 1'b0;
      e_dm = '0; e_dl = '0;
      return;
    end
    e_fe = 1'b0;
    e_pe = 1'b0;
    xfer = e_valid && m_ready;
    if (s_valid) begin
      if (!e_in_frame) begin
        if (s_sof) begin
          e_in_frame = 1'b1;
          e_bits.delete();
          e_bits.push_back(s_bit);
        end
      end else if (s_sof && e_bits.size() != 0) begin
        e_fe = 1'b1;
        e_bits.delete();
        e_bits.push_back(s_bit);
      end else if (e_bits.size() == W) begin
        // only reachable with parity: this bit is the even-parity bit
        if (s_bit == ones_parity()) begin
          complete = 1'b1;
          wm = pack(1'b1);
          wl = pack(1'b0);
        end else begin
          e_pe = 1'b1;
        end
        e_bits.delete();
      end else begin
        e_bits.push_back(s_bit);
        if (e_bits.size() == W && !PAR_EN) begin
          complete = 1'b1;
          wm = pack(1'b1);
          wl = pack(1'b0);
          e_bits.delete();
        end
      end
    end
    if (complete) begin
      if (!e_valid || m_ready) begin
        e_dm = wm; e_dl = wl; e_valid = 1'b1;
      end else begin
        e_ov = 1'b1;
      end
    end else if (xfer) begin
      e_valid = 1'b0;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    chk("m_valid_msb", v_msb, e_valid);
    chk("m_valid_lsb", v_lsb, e_valid);
    chk("m_data_msb", d_msb, e_dm);
    chk("m_data_lsb", d_lsb, e_dl);
    chk("overrun_msb", ov_msb, e_ov);
    chk("overrun_lsb", ov_lsb, e_ov);
    chk("frame_err_msb", fe_msb, e_fe);
    chk("frame_err_lsb", fe_lsb, e_fe);
    chk("parity_err_msb", pe_msb, e_pe);
    chk("parity_err_lsb", pe_lsb, e_pe);
    if (fe_msb === 1'b1) fe_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit b, input bit sof, input bit rdy, input bit r);
    rst = r; s_valid = v; s_bit = b; s_sof = sof; m_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // w sent w[7] first; rdy_last applies to the final bit of the word
  // (the parity bit when parity is built in).
  task automatic send_word(input logic [W-1:0] w, input bit sof_first,
                           input bit rdy, input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      bit last = (i == 0) && !PAR_EN;
      drive(1'b1, w[i], sof_first && (i == W - 1), last ? rdy_last : rdy, 1'b0);
    end
    if (PAR_EN) drive(1'b1, ^w, 1'b0, rdy_last, 1'b0);
  endtask

  initial begin
    int fe0;
    do_reset();
    chk("reset_valid", v_msb, 1'b0);
    chk("reset_data", d_msb, 8'h00);
    chk("reset_overrun", ov_msb, 1'b0);

    // 1,0,1,0,0,1,0,1 reads 0xA5 in either bit order
    send_word(8'hA5, 1'b1, 1'b1, 1'b1);
    chk("a5_valid", v_msb, 1'b1);
    chk("a5_msb", d_msb, 8'hA5);
    chk("a5_lsb", d_lsb, 8'hA5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_one_cycle", v_msb, 1'b0);

    // 1,1,0,0,0,0,0,0 -> 0xC0 MSB-first, 0x03 LSB-first
    send_word(8'hC0, 1'b0, 1'b1, 1'b1);
    chk("c0_msb", d_msb, 8'hC0);
    chk("03_lsb", d_lsb, 8'h03);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // overrun: 0x11 held, 0x22 dropped
    do_reset();
    send_word(8'h11, 1'b1, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    chk("ovr_data_held", d_msb, 8'h11);
    chk("ovr_set", ov_msb, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_drained", v_msb, 1'b0);
    chk("ovr_sticky", ov_msb, 1'b1);

    // completion coinciding with transfer of held word
    do_reset();
    send_word(8'h11, 1'b1, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b1);
    chk("coin_valid", v_msb, 1'b1);
    chk("coin_data", d_msb, 8'h22);
    chk("coin_no_ovr", ov_msb, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // s_sof at bit 4 restarts the word
    do_reset();
    fe0 = fe_seen;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(8'h3C, 1'b1, 1'b1, 1'b1);
    chk("sof_mid_data", d_msb, 8'h3C);
    chk("sof_mid_valid", v_msb, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sof_mid_pulses", fe_seen - fe0, 1);

    // reset at bit 5, then bits without s_sof produce nothing
    send_word(8'h5A, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_valid", v_msb, 1'b0);
    chk("rst_mid_data", d_msb, 8'h00);
    chk("rst_mid_ovr", ov_msb, 1'b0);
    send_word(8'hFF, 1'b0, 1'b1, 1'b1);
    chk("no_sof_nothing", v_msb, 1'b0);

`ifdef SIPO_DESER_PARITY_EN
    do_reset();
    for (int i = W - 1; i >= 0; i--) drive(1'b1, W'(8'hA5) >> i, i == W - 1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("par_bad_pulse", pe_msb, 1'b1);
    chk("par_bad_novalid", v_msb, 1'b0);
    for (int i = W - 1; i >= 0; i--) drive(1'b1, W'(8'hA5) >> i, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("par_ok_data", d_msb, 8'hA5);
    chk("par_ok_valid", v_msb, 1'b1);
`endif

    // randomized traffic with occasional resets to clear the sticky flag
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
            (c % 500 == 0) || ($urandom_range(0, 599) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-to-parallel deserializer that consumes the registered single-bit stream produced by the team's D flip-flop stage and assembles it into WIDTH-bit words. Frames are aligned by a start-of-frame marker, and completed words are presented on a valid/ready output port through a single holding register. Overrun and misalignment are flagged to the control block.

## Interface
- WIDTH, 8, data bits per word (2..32)
- MSB_FIRST, 1, 1: first received bit lands in bit WIDTH-1; 0: first bit lands in bit 0
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- s_bit  input  1  serial data bit, sampled when s_valid=1
- s_valid  input  1  s_bit is valid this cycle (no backpressure on input)
- s_sof  input  1  qualifies s_bit as bit 0 of a new frame; ignored when s_valid=0
- m_data  output  WIDTH  assembled word
- m_valid  output  1  m_data holds an undelivered word
- m_ready  input  1  downstream accepts m_data when m_valid=1
- overrun  output  1  sticky: a completed word was dropped
- frame_err  output  1  one-cycle pulse: s_sof arrived mid-word
- parity_err  output  1  one-cycle pulse: parity check failed (0 when parity is compiled out)

## Operation
- Reset: state IDLE, bit counter 0, shift register 0; m_data=0, m_valid=0, overrun=0, frame_err=0, parity_err=0.
- FSM states:
  - IDLE: waits for s_valid & s_sof. That bit is stored as bit 0 and the FSM goes to SHIFT with counter=1.
  - SHIFT: stores each valid bit and increments the counter.
  - PAR: exists only with the parity feature compiled in.
- Word complete: the valid bit that makes counter=WIDTH, or the parity bit in PAR.
  - On completion the counter wraps to 0 and the FSM stays in SHIFT. Back-to-back words need no further s_sof.
- Load rule at completion:
  - If m_valid=0, or m_valid & m_ready in the same cycle, the word is loaded into m_data.
  - Otherwise the word is dropped, overrun is set, and m_data and m_valid are unchanged.
- overrun is cleared only by rst.
- s_sof with s_valid while counter≠0 in SHIFT or PAR:
  - The partial word is discarded and the current bit becomes bit 0 (counter=1).
  - frame_err pulses.
  - An s_sof bit at counter=0 is a normal start, with no error.
- Handshake:
  - Transfer occurs when m_valid & m_ready.
  - m_valid drops the next cycle unless a new word loads in the same cycle.
  - m_data is stable while m_valid=1 and m_ready=0.
- s_valid=0 cycles hold all state. There is no timeout.

## Timing
- Latency: m_valid rises the cycle after the clock edge that accepts the final bit (parity bit if enabled).
- Throughput: one bit per cycle sustained. With m_ready tied high, no overrun is possible for WIDTH≥2.
- frame_err and parity_err are registered and asserted for exactly the cycle after the offending bit.
- Reset mid-word discards all partial and held data. The first output after reset requires a fresh s_sof.

## Configuration
- Macro: SIPO_DESER_PARITY_EN.
- Defined:
  - After WIDTH data bits the FSM enters PAR, and the next valid bit is an even-parity bit over the word.
  - Mismatch: the word is discarded (never loaded and no overrun), parity_err pulses, and the FSM returns to SHIFT with counter 0.
  - Match: load rule as above.
- Undefined: PAR state and parity logic are absent, and parity_err is tied 0.

## Structure
- Package sipo_deser_pkg holds:
  - State enum typedef (IDLE, SHIFT, PAR).
  - Localparam for counter width, $clog2(WIDTH+1).
- Sub-module sipo_deser_out_reg: the WIDTH-bit holding register with valid/ready handshake, load strobe, and overrun detection.
- The top level owns the FSM, counter and shift register.

## Test plan
- WIDTH=8, MSB_FIRST=1; s_sof on the first bit, bits 1,0,1,0,0,1,0,1; m_ready=1 -> m_data=8'hA5, with m_valid high for 1 cycle starting the cycle after the 8th bit.
- Same bits with MSB_FIRST=0 -> m_data=8'hA5 (bit order reversed: 8'b10100101 received LSB-first reads 0xA5). Repeat with 1,1,0,0,0,0,0,0 -> 8'h03.
- m_ready=0; words 8'h11 then 8'h22 back-to-back -> m_data stays 8'h11, overrun=1 after the 16th bit. Raise m_ready -> one transfer of 8'h11, and overrun stays 1.
- Completion coinciding with m_ready=1 on a held word: 8'h11 held, 8'h22 completes in the transfer cycle -> 8'h22 loaded, m_valid stays 1, overrun=0.
- s_sof at bit 4, then 8 bits forming 8'h3C -> frame_err pulses once, output 8'h3C only. rst asserted at bit 5 of a word -> all outputs 0; bits without s_sof produce nothing.
- With SIPO_DESER_PARITY_EN: 8'hA5 then parity bit 1 -> parity_err pulse, m_valid stays 0. 8'hA5 then parity bit 0 -> m_data=8'hA5.
